// File: rtl/mixer_seq_pkg.sv
// Shared types and constants for the sequenced LO mixer (mixer_seq).
package mixer_pkg;

  localparam int DATA_W = 20;
  localparam int AMPL_W = 25;
  localparam int SH1    = 15;
  localparam int SH2    = 23;
  localparam int CNT_W  = 16;
  localparam int PROD_W = DATA_W + AMPL_W;

  localparam logic [AMPL_W-1:0] AMPL_RESET = 25'h028619A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL1 = 2'd1,
    ST_MUL2 = 2'd2,
    ST_OUT  = 2'd3
  } mixer_state_t;

  // Sign-extend a DATA_W operand to the AMPL_W multiplier port.
  function automatic logic [AMPL_W-1:0] sext_data(input logic [DATA_W-1:0] v);
    return {{(AMPL_W - DATA_W){v[DATA_W-1]}}, v};
  endfunction

endpackage

// File: rtl/mixer_seq_mul_slice.sv
// Shared signed multiplier with per-pass operand select, optional rounding and
// product slice select. Rounding is enabled by defining MIXER_SEQ_ROUND_EN.
module mixer_mul_slice
  import mixer_pkg::*;
#(
  parameter int P_DATA_W = DATA_W,
  parameter int P_AMPL_W = AMPL_W,
  parameter int P_SH1    = SH1,
  parameter int P_SH2    = SH2
) (
  input  logic                pass2_i,
  input  logic [P_DATA_W-1:0] x_i,
  input  logic [P_DATA_W-1:0] lo_i,
  input  logic [P_DATA_W-1:0] inter_i,
  input  logic [P_AMPL_W-1:0] ampl_i,
  output logic [P_DATA_W-1:0] result_o
);

  localparam int P_PROD_W = P_DATA_W + P_AMPL_W;

  logic signed [P_DATA_W-1:0] op_a;
  logic signed [P_AMPL_W-1:0] op_b;
  logic signed [P_PROD_W-1:0] prod;
  logic        [P_PROD_W-1:0] prod_adj;
  logic                       unused_prod_bits;

  always_comb begin
    op_a = pass2_i ? inter_i : x_i;
    op_b = pass2_i ? ampl_i : {{(P_AMPL_W - P_DATA_W){lo_i[P_DATA_W-1]}}, lo_i};
  end

  assign prod = op_a * op_b;

`ifdef MIXER_SEQ_ROUND_EN
  // Half an output LSB is added below each slice: round half toward +inf.
  localparam logic [P_PROD_W-1:0] RND1 = {{(P_PROD_W-1){1'b0}}, 1'b1} << (P_SH1 - 1);
  localparam logic [P_PROD_W-1:0] RND2 = {{(P_PROD_W-1){1'b0}}, 1'b1} << (P_SH2 - 1);
  assign prod_adj = prod + (pass2_i ? RND2 : RND1);
`else
  assign prod_adj = prod;
`endif

  assign result_o = pass2_i ? prod_adj[P_SH2+P_DATA_W-1:P_SH2]
                            : prod_adj[P_SH1+P_DATA_W-1:P_SH1];

  // Bits outside both slices wrap away silently.
  assign unused_prod_bits = ^{prod_adj[P_PROD_W-1:P_SH2+P_DATA_W], prod_adj[P_SH1-1:0]};

endmodule

// File: rtl/mixer_seq.sv
// Sequenced LO mixer: one multiplier shared over sample*LO and *amplitude passes,
// 1 result per 3 cycles. Optional rounding via MIXER_SEQ_ROUND_EN.
module mixer_seq
  import mixer_pkg::*;
#(
  parameter int                DATA_W_P   = DATA_W,
  parameter int                AMPL_W_P   = AMPL_W,
  parameter logic [AMPL_W-1:0] AMPL_RST_P = AMPL_RESET,
  parameter int                SH1_P      = SH1,
  parameter int                SH2_P      = SH2,
  parameter int                CNT_W_P    = CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W_P-1:0] in_data,
  input  logic [DATA_W_P-1:0] lo_data,
  input  logic                ampl_wr,
  input  logic [AMPL_W_P-1:0] ampl_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W_P-1:0] out_data,
  output logic                busy,
  output logic [CNT_W_P-1:0]  sample_cnt
);

  mixer_state_t          state_q, state_d;
  logic [DATA_W_P-1:0]   x_q, x_d;
  logic [DATA_W_P-1:0]   lo_q, lo_d;
  logic [AMPL_W_P-1:0]   a_q, a_d;
  logic [DATA_W_P-1:0]   inter_q, inter_d;
  logic [DATA_W_P-1:0]   out_q, out_d;
  logic [AMPL_W_P-1:0]   ampl_q, ampl_d;
  logic [CNT_W_P-1:0]    cnt_q, cnt_d;
  logic                  accept;
  logic                  pass2;
  logic [DATA_W_P-1:0]   mul_res;

  assign in_ready   = (state_q == ST_IDLE) | ((state_q == ST_OUT) & out_ready);
  assign accept     = in_valid & in_ready;
  assign pass2      = (state_q == ST_MUL2);
  assign out_valid  = (state_q == ST_OUT);
  assign busy       = (state_q != ST_IDLE);
  assign out_data   = out_q;
  assign sample_cnt = cnt_q;

  mixer_mul_slice #(
    .P_DATA_W (DATA_W_P),
    .P_AMPL_W (AMPL_W_P),
    .P_SH1    (SH1_P),
    .P_SH2    (SH2_P)
  ) u_mul (
    .pass2_i  (pass2),
    .x_i      (x_q),
    .lo_i     (lo_q),
    .inter_i  (inter_q),
    .ampl_i   (a_q),
    .result_o (mul_res)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    lo_d    = lo_q;
    a_d     = a_q;
    inter_d = inter_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    ampl_d  = ampl_wr ? ampl_data : ampl_q;

    // The snapshot reads ampl_q, so a same-cycle write only affects later samples.
    if (accept) begin
      x_d  = in_data;
      lo_d = lo_data;
      a_d  = ampl_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_MUL1;
      end
      ST_MUL1: begin
        inter_d = mul_res;
        state_d = ST_MUL2;
      end
      ST_MUL2: begin
        out_d   = mul_res;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          cnt_d   = cnt_q + CNT_W_P'(1);
          state_d = accept ? ST_MUL1 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      inter_q <= '0;
      out_q   <= '0;
      ampl_q  <= AMPL_RST_P;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      inter_q <= inter_d;
      out_q   <= out_d;
      ampl_q  <= ampl_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mixer_seq.sv
// Directed, table-driven bench for mixer_seq; honours MIXER_SEQ_ROUND_EN.
module tb_mixer_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_data;
  logic [19:0] lo_data;
  logic        ampl_wr;
  logic [24:0] ampl_data;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic        busy;
  logic [15:0] sample_cnt;

  int n_checks = 0;
  int n_fails  = 0;
  int exp_cnt  = 0;

  localparam logic [24:0] A_DEF  = 25'h028619A;
  localparam logic [24:0] A_ONE  = 25'h0800000;
  localparam logic [24:0] A_NEG1 = 25'h1800000;

`ifdef MIXER_SEQ_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    logic [24:0] ampl;
    logic [19:0] x;
    logic [19:0] lo;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[9];

  mixer_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .lo_data    (lo_data),
    .ampl_wr    (ampl_wr),
    .ampl_data  (ampl_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .sample_cnt (sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic set_ampl(input logic [24:0] v);
    @(negedge clk);
    ampl_wr   = 1'b1;
    ampl_data = v;
    @(negedge clk);
    ampl_wr   = 1'b0;
  endtask

  // One sample through the block with out_ready high; lat counts edges from accept edge to out_valid.
  task automatic run_one(input logic [19:0] x, input logic [19:0] lo, input bit wr,
                         input logic [24:0] wd, output logic [19:0] res, output int lat);
    int w;
    @(negedge clk);
    in_data   = x;
    lo_data   = lo;
    in_valid  = 1'b1;
    ampl_wr   = wr;
    ampl_data = wd;
    out_ready = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ampl_wr  = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = out_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [19:0] res;
    int          lat;
    logic [19:0] bx[4];
    logic [19:0] bl[4];
    logic [19:0] be[4];
    logic [19:0] got[4];
    int          acc[4];
    int          idx;
    int          nout;
    bit          fire;
    logic [19:0] hold;
    int          w;

    vecs[0] = '{A_DEF,  20'h08000, 20'h08000, RND ? 20'h02862 : 20'h02861};
    vecs[1] = '{A_DEF,  20'hF8000, 20'h08000, 20'hFD79E};
    vecs[2] = '{A_ONE,  20'h04000, 20'h08000, 20'h04000};
    vecs[3] = '{A_ONE,  20'h00003, 20'h00003, 20'h00000};
    vecs[4] = '{A_ONE,  20'hFFFFF, 20'h00001, RND ? 20'h00000 : 20'hFFFFF};
    vecs[5] = '{A_ONE,  20'h7FFFF, 20'h7FFFF, 20'hFFFE0};
    vecs[6] = '{A_ONE,  20'h00001, 20'h0C000, RND ? 20'h00002 : 20'h00001};
    vecs[7] = '{A_ONE,  20'h80000, 20'h80000, 20'h00000};
    vecs[8] = '{A_NEG1, 20'h04000, 20'h08000, 20'hFC000};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; lo_data = '0;
    ampl_wr = 1'b0; ampl_data = '0; out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(sample_cnt), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 9; i++) begin
      set_ampl(vecs[i].ampl);
      run_one(vecs[i].x, vecs[i].lo, 1'b0, '0, res, lat);
      exp_cnt++;
      chk($sformatf("vec%0d_data", i), 32'(res), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_cnt", i), 32'(sample_cnt), 32'(exp_cnt));
    end

    // Back-to-back with in_valid held high.
    set_ampl(A_ONE);
    bx[0] = vecs[2].x; bl[0] = vecs[2].lo; be[0] = vecs[2].exp;
    bx[1] = vecs[4].x; bl[1] = vecs[4].lo; be[1] = vecs[4].exp;
    bx[2] = vecs[5].x; bl[2] = vecs[5].lo; be[2] = vecs[5].exp;
    bx[3] = vecs[6].x; bl[3] = vecs[6].lo; be[3] = vecs[6].exp;
    idx = 0; nout = 0;
    for (int k = 0; k < 4; k++) begin acc[k] = -1; got[k] = '0; end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 18; cyc++) begin
      @(negedge clk);
      if (idx < 4) begin
        in_valid = 1'b1; in_data = bx[idx]; lo_data = bl[idx];
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && nout < 4) begin
        got[nout] = out_data;
        nout++;
      end
      fire = in_valid && in_ready;
      if (fire) acc[idx] = cyc;
      @(posedge clk);
      if (fire) idx++;
    end
    in_valid = 1'b0;
    exp_cnt += 4;
    chk("b2b_first_accept", 32'(acc[0]), 32'd0);
    for (int k = 1; k < 4; k++)
      chk($sformatf("b2b_accept%0d_cycle", k), 32'(acc[k]), 32'(3 * k));
    for (int k = 0; k < 4; k++)
      chk($sformatf("b2b_result%0d", k), 32'(got[k]), 32'(be[k]));
    chk("b2b_cnt", 32'(sample_cnt), 32'(exp_cnt));

    // Backpressure: result held for 5 cycles, then one transfer.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 20'h08000; lo_data = 20'h08000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    hold = 20'h08000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_data", k), 32'(out_data), 32'(hold));
      chk($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
    end
    chk("bp_cnt_stalled", 32'(sample_cnt), 32'(exp_cnt));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt++;
    chk("bp_cnt_release", 32'(sample_cnt), 32'(exp_cnt));
    @(negedge clk);
    chk("bp_valid_after", 32'(out_valid), 32'd0);
    chk("bp_cnt_once", 32'(sample_cnt), 32'(exp_cnt));

    // Reset while the sample sits in MUL2.
    @(negedge clk);
    in_valid = 1'b1; in_data = 20'h04000; lo_data = 20'h08000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt", 32'(sample_cnt), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_valid", k), 32'(out_valid), 32'd0);
    end

    // Amplitude write in the accept cycle: sample keeps the restored default.
    run_one(20'h08000, 20'h08000, 1'b1, A_ONE, res, lat);
    exp_cnt++;
    chk("ampl_same_cycle_data", 32'(res), RND ? 32'h02862 : 32'h02861);
    chk("ampl_same_cycle_cnt", 32'(sample_cnt), 32'(exp_cnt));
    run_one(20'h08000, 20'h08000, 1'b0, '0, res, lat);
    exp_cnt++;
    chk("ampl_new_data", 32'(res), 32'h08000);
    chk("ampl_new_cnt", 32'(sample_cnt), 32'(exp_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mixer_seq.md
Name: mixer_seq

Overview:
- Sequenced, resource-shared version of the LO mixer: one signed 20x25 multiplier is time-multiplexed over both mixing products.
  - Pass 1: sample × LO.
  - Pass 2: intermediate × amplitude.
- Sits between the interpolator output and the modulator loop. Valid/ready handshakes on both sides.
- Adds a run-time programmable amplitude register.
- Trades throughput (1 sample / 3 cycles) for a single multiplier and a short critical path.

Parameters:
- DATA_W, 20, width of sample, LO and result (signed fixed point)
- AMPL_W, 25, width of amplitude coefficient (signed)
- AMPL_RESET, 25'h028619A, amplitude after reset (0.3154786)
- SH1, 15, LSB index of pass-1 product slice
- SH2, 23, LSB index of pass-2 product slice
- CNT_W, 16, width of sample counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample/LO pair valid
- in_ready  out  1  block accepts pair this cycle
- in_data  in  DATA_W  interpolated sample, signed
- lo_data  in  DATA_W  LO value, signed
- ampl_wr  in  1  load amplitude register
- ampl_data  in  AMPL_W  new amplitude, signed
- out_valid  out  1  mixed result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DATA_W  mixed result, signed
- busy  out  1  high in any state other than IDLE
- sample_cnt  out  CNT_W  count of completed output transfers

Behaviour:
- Reset (async assert, sync deassert by upstream):
  - state=IDLE; out_valid=0, out_data=0, busy=0, sample_cnt=0.
  - ampl_reg=AMPL_RESET; internal operand and intermediate registers = 0.
- States: IDLE, MUL1, MUL2, OUT.
- in_ready = (state==IDLE) | (state==OUT & out_ready). Combinational; no dependence on in_valid.
- Accept = in_valid & in_ready. On accept:
  - Latch x=in_data and lo=lo_data.
  - Snapshot a=ampl_reg; the snapshot is used for this sample only.
  - Go to MUL1.
- MUL1: multiplier A=x, B=sign-extended lo. inter ← prod[SH1+DATA_W-1:SH1] = prod[34:15], truncating. Go to MUL2.
- MUL2: multiplier A=inter, B=a. out_data ← prod[SH2+DATA_W-1:SH2] = prod[42:23]. Go to OUT.
- OUT:
  - out_valid=1; out_data held stable until the transfer completes.
  - On out_ready: sample_cnt+1 (wraps at 2^CNT_W, no flag). Next state is MUL1 if accept in the same cycle, otherwise IDLE.
- Latency: out_valid rises 3 clk edges after the accept edge. Sustained throughput is 1 result per 3 cycles with out_ready held high.
- The multiplier is full precision (45-bit signed). Discarded upper bits wrap silently; no saturation.
- ampl_wr: ampl_reg ← ampl_data in any state.
  - A sample already in flight keeps its snapshot.
  - If ampl_wr and accept occur in the same cycle, the snapshot takes the OLD value.
- in_valid while not ready: ignored. Upstream holds the data (standard valid/ready).
- out_ready while out_valid=0: no effect.
- rst_n asserted mid-operation: the in-flight sample is discarded and every output returns immediately to its reset value.

Optional Feature:
- Macro MIXER_SEQ_ROUND_EN.
- Defined: each slice adds 1 at bit position (LSB index − 1) before truncation: +2^14 in pass 1, +2^22 in pass 2. This is round-half-up toward +inf. Latency is unchanged.
- Undefined: plain truncation (floor), as specified above.

Decomposition:
- Shared package mixer_pkg holds:
  - state enum mixer_state_t;
  - constants DATA_W, AMPL_W, SH1, SH2, AMPL_RESET.
- One natural sub-module: mixer_mul_slice. It is the combinational signed 20x25 multiplier plus rounding and slice-select mux, driven by the FSM's operand and pass select.

Test Plan:
- Reset, then idle: in_ready=1, out_valid=0, sample_cnt=0, busy=0.
- in_data=0x08000, lo_data=0x08000, default amplitude, out_ready=1:
  - out_valid exactly 3 cycles after accept;
  - out_data=0x02861, or 0x02862 with MIXER_SEQ_ROUND_EN;
  - sample_cnt=1.
- in_data=0xF8000, lo_data=0x08000 → out_data=0xFD79E, both with and without the macro.
- Back-to-back: in_valid held with 4 samples, out_ready=1 → accepts on cycles 0, 3, 6, 9 and results in order.
- Backpressure: out_ready=0 for 5 cycles → out_data stable, in_ready=0. Then release; sample_cnt increments once.
- Amplitude update:
  - ampl_wr=1 with ampl_data=0x0800000 in the same cycle as an accept → that sample uses 0x028619A.
  - Next sample with 0x08000×0x08000 → out_data=0x08000.
- Assert rst_n low while in MUL2 → out_valid=0 immediately; ampl_reg restored; no spurious output after release.
